// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction prefetch queue with a three-state bus fetch sequencer
//
// Ports:
//   clock, reset_n      system clock, synchronous active-low reset
//   locked              global enable; low freezes all state
//   flush, flush_cs/ip  discard the queue and restart fetching at flush_cs:flush_ip
//   eu_hold             execution unit wants the bus; blocks new fetches
//   address, rd         fetch address and read strobe
//   in                  memory read data, valid the cycle after rd
//   biu_idle            sequencer idle, bus free for the execution unit
//   q_valid, q_byte,    head byte of the queue and its code offset
//   q_ip, q_count       number of bytes held
//   q_pop               consume the head byte
module prefetch_queue #(
    parameter int          DW       = 8,
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_CS = 16'hF000,
    parameter logic [15:0] RESET_IP = 16'hFFF0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   locked,
    input  logic                   flush,
    input  logic [15:0]            flush_cs,
    input  logic [15:0]            flush_ip,
    input  logic                   eu_hold,
    output logic [19:0]            address,
    output logic                   rd,
    input  logic [DW-1:0]          in,
    output logic                   biu_idle,
    output logic                   q_valid,
    output logic [7:0]             q_byte,
    output logic [15:0]            q_ip,
    output logic [$clog2(DEPTH):0] q_count,
    input  logic                   q_pop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   fcs;
    logic [15:0]   fip;
    logic [7:0]    q_data [DEPTH];
    logic [15:0]   q_off  [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [15:0]   in_wide;
    logic          two_bytes;
    logic          odd_byte;
    logic [CW-1:0] w;
    logic [CW-1:0] free;
    logic [15:0]   fetch_off;
    logic          pop;
    logic          push;
    logic [7:0]    first_byte;

    // Zero-extend the bus so byte lane selects are legal for both widths.
    always_comb begin
        in_wide            = '0;
        in_wide[DW-1:0]    = in;
    end

    // On a 16-bit bus an odd offset fetches the enclosing word and keeps only the upper lane.
    assign two_bytes  = (DW == 16) && !fip[0];
    assign odd_byte   = (DW == 16) && fip[0];
    assign w          = two_bytes ? CW'(2) : CW'(1);
    assign free       = CW'(DEPTH) - count;
    assign fetch_off  = (DW == 16) ? {fip[15:1], 1'b0} : fip;
    assign first_byte = odd_byte ? in_wide[15:8] : in_wide[7:0];

    // fip only moves on the CAPTURE edge, so the address is stable across FETCH and CAPTURE.
    assign address  = {fcs, 4'h0} + {4'h0, fetch_off};
    assign rd       = (state == FETCH);
    assign biu_idle = (state == IDLE);

    assign q_valid = (count != '0);
    assign q_count = count;
    assign q_byte  = q_data[head];
    assign q_ip    = q_off[head];

    assign pop  = locked && !flush && q_pop && (count != '0);
    assign push = locked && !flush && (state == CAPTURE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            fcs   <= RESET_CS;
            fip   <= RESET_IP;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (locked) begin
            if (flush) begin
                state <= IDLE;
                fcs   <= flush_cs;
                fip   <= flush_ip;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!eu_hold && (free >= w)) begin
                            state <= FETCH;
                        end
                    end
                    FETCH: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        state        <= IDLE;
                        q_data[tail] <= first_byte;
                        q_off[tail]  <= fip;
                        if (two_bytes) begin
                            q_data[tail + PW'(1)] <= in_wide[15:8];
                            q_off[tail + PW'(1)]  <= fip + 16'd1;
                        end
                        tail <= tail + PW'(w);
                        fip  <= fip + 16'(w);
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count - CW'(pop) + (push ? w : '0);
            end
        end
    end

endmodule
